// File: rtl/lsq_param.sv
// In-order load/store queue: circular entry buffer with CDB snoop and bypass,
// head-of-queue issue to the data cache (loads) or to the ROB (stores),
// misalignment reporting, registered CDB output and synchronous flush.
module lsq_param #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic              disp_store,
    input  logic [1:0]        disp_size,
    input  logic              disp_unsigned,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic [ADDR_W-1:0] disp_offset,
    input  logic [TAG_W:0]    disp_lock1,
    input  logic [DATA_W-1:0] disp_data1,
    input  logic [TAG_W:0]    disp_lock2,
    input  logic [DATA_W-1:0] disp_data2,
    output logic              full,
    input  logic [TAG_W:0]    cdb_a_index,
    input  logic [DATA_W-1:0] cdb_a_data,
    input  logic [TAG_W:0]    cdb_b_index,
    input  logic [DATA_W-1:0] cdb_b_data,
    input  logic              rob_stall,
    output logic              cdb_out_valid,
    output logic [TAG_W:0]    cdb_out_index,
    output logic [DATA_W-1:0] cdb_out_data,
    output logic [ADDR_W-1:0] cdb_out_addr,
    output logic [3:0]        cdb_out_mask,
    output logic              cdb_out_exc,
    output logic              dcache_read,
    output logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_read_done,
    input  logic [DATA_W-1:0] dcache_read_data
);

    localparam int unsigned LOCK_W = TAG_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [LOCK_W-1:0] NO_LOCK = {1'b1, {TAG_W{1'b0}}};

    typedef struct packed {
        logic              valid;
        logic              store;
        logic [1:0]        size;
        logic              uns;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] offset;
        logic [LOCK_W-1:0] lock1;
        logic [DATA_W-1:0] data1;
        logic [LOCK_W-1:0] lock2;
        logic [DATA_W-1:0] data2;
    } entry_t;

    typedef enum logic {IDLE, LOAD} state_e;

    entry_t            ent_q [DEPTH];
    entry_t            new_ent;
    entry_t            head;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    state_e            state_q;
    state_e            state_d;

    logic              push;
    logic              pop;
    logic              head_ready;
    logic              head_mis;
    logic [ADDR_W-1:0] eff;
    logic [DATA_W-1:0] ld_sh;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_raw;
    logic [DATA_W-1:0] st_data;
    logic [3:0]        st_lanes;
    logic [3:0]        st_mask;

    logic              out_v_d;
    logic [LOCK_W-1:0] out_idx_d;
    logic [DATA_W-1:0] out_data_d;
    logic [ADDR_W-1:0] out_addr_d;
    logic [3:0]        out_mask_d;
    logic              out_exc_d;
    logic              rd_d;
    logic [ADDR_W-1:0] rd_addr_d;

    assign full = (count == CNT_W'(DEPTH));
    assign push = disp_valid && !full;
    assign head = ent_q[rd_ptr];

    // New entry from dispatch, with same-cycle CDB bypass (port A has priority)
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.store  = disp_store;
        new_ent.size   = disp_size;
        new_ent.uns    = disp_unsigned;
        new_ent.tag    = disp_tag;
        new_ent.offset = disp_offset;
        new_ent.lock1  = disp_lock1;
        new_ent.data1  = disp_data1;
        new_ent.lock2  = disp_lock2;
        new_ent.data2  = disp_data2;
        if (!disp_lock1[LOCK_W-1] && disp_lock1 == cdb_a_index) begin
            new_ent.lock1 = NO_LOCK;
            new_ent.data1 = cdb_a_data;
        end else if (!disp_lock1[LOCK_W-1] && disp_lock1 == cdb_b_index) begin
            new_ent.lock1 = NO_LOCK;
            new_ent.data1 = cdb_b_data;
        end
        if (!disp_lock2[LOCK_W-1] && disp_lock2 == cdb_a_index) begin
            new_ent.lock2 = NO_LOCK;
            new_ent.data2 = cdb_a_data;
        end else if (!disp_lock2[LOCK_W-1] && disp_lock2 == cdb_b_index) begin
            new_ent.lock2 = NO_LOCK;
            new_ent.data2 = cdb_b_data;
        end
    end

    // Head address, alignment, store lane placement and load extraction
    always_comb begin
        eff        = ADDR_W'(head.data1) + head.offset;
        head_ready = head.valid && head.lock1[LOCK_W-1] &&
                     (!head.store || head.lock2[LOCK_W-1]);
        head_mis   = (head.size == 2'b11) ||
                     (head.size == 2'b01 && eff[0]) ||
                     (head.size == 2'b10 && eff[1:0] != 2'b00);
        case (head.size)
            2'b00: begin
                st_raw   = DATA_W'(head.data2[7:0]);
                st_lanes = 4'b0001;
            end
            2'b01: begin
                st_raw   = DATA_W'(head.data2[15:0]);
                st_lanes = 4'b0011;
            end
            default: begin
                st_raw   = head.data2;
                st_lanes = 4'b1111;
            end
        endcase
        st_data = st_raw << {eff[1:0], 3'b000};
        st_mask = st_lanes << eff[1:0];
        ld_sh   = dcache_read_data >> {eff[1:0], 3'b000};
        case (head.size)
            2'b00:   ld_data = head.uns ? DATA_W'(ld_sh[7:0])
                                        : {{(DATA_W-8){ld_sh[7]}}, ld_sh[7:0]};
            2'b01:   ld_data = head.uns ? DATA_W'(ld_sh[15:0])
                                        : {{(DATA_W-16){ld_sh[15]}}, ld_sh[15:0]};
            default: ld_data = dcache_read_data;
        endcase
    end

    // Issue FSM: next state, pop and next values of registered outputs
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        out_v_d    = 1'b0;
        out_idx_d  = NO_LOCK;
        out_data_d = '0;
        out_addr_d = '0;
        out_mask_d = '0;
        out_exc_d  = 1'b0;
        rd_d       = dcache_read;
        rd_addr_d  = dcache_addr;
        case (state_q)
            IDLE: begin
                if (head_ready) begin
                    if (head_mis) begin
                        if (!head.store || !rob_stall) begin
                            pop        = 1'b1;
                            out_v_d    = 1'b1;
                            out_idx_d  = {1'b0, head.tag};
                            out_addr_d = eff;
                            out_exc_d  = 1'b1;
                        end
                    end else if (head.store) begin
                        if (!rob_stall) begin
                            pop        = 1'b1;
                            out_v_d    = 1'b1;
                            out_idx_d  = {1'b0, head.tag};
                            out_data_d = st_data;
                            out_addr_d = eff;
                            out_mask_d = st_mask;
                        end
                    end else begin
                        state_d   = LOAD;
                        rd_d      = 1'b1;
                        rd_addr_d = {eff[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            LOAD: begin
                if (dcache_read_done) begin
                    pop        = 1'b1;
                    out_v_d    = 1'b1;
                    out_idx_d  = {1'b0, head.tag};
                    out_data_d = ld_data;
                    out_addr_d = eff;
                    rd_d       = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, pointers, count and registered outputs
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q       <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            cdb_out_valid <= 1'b0;
            cdb_out_index <= NO_LOCK;
            cdb_out_data  <= '0;
            cdb_out_addr  <= '0;
            cdb_out_mask  <= '0;
            cdb_out_exc   <= 1'b0;
            dcache_read   <= 1'b0;
            dcache_addr   <= '0;
        end else begin
            state_q       <= state_d;
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            count         <= count + CNT_W'(push) - CNT_W'(pop);
            cdb_out_valid <= out_v_d;
            cdb_out_index <= out_idx_d;
            cdb_out_data  <= out_data_d;
            cdb_out_addr  <= out_addr_d;
            cdb_out_mask  <= out_mask_d;
            cdb_out_exc   <= out_exc_d;
            dcache_read   <= rd_d;
            dcache_addr   <= rd_addr_d;
        end
    end

    // Entry storage: CDB wakeup, pop clear and dispatch write
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_q[i].valid && !ent_q[i].lock1[LOCK_W-1]) begin
                    if (ent_q[i].lock1 == cdb_a_index) begin
                        ent_q[i].lock1 <= NO_LOCK;
                        ent_q[i].data1 <= cdb_a_data;
                    end else if (ent_q[i].lock1 == cdb_b_index) begin
                        ent_q[i].lock1 <= NO_LOCK;
                        ent_q[i].data1 <= cdb_b_data;
                    end
                end
                if (ent_q[i].valid && !ent_q[i].lock2[LOCK_W-1]) begin
                    if (ent_q[i].lock2 == cdb_a_index) begin
                        ent_q[i].lock2 <= NO_LOCK;
                        ent_q[i].data2 <= cdb_a_data;
                    end else if (ent_q[i].lock2 == cdb_b_index) begin
                        ent_q[i].lock2 <= NO_LOCK;
                        ent_q[i].data2 <= cdb_b_data;
                    end
                end
            end
            if (pop)  ent_q[rd_ptr].valid <= 1'b0;
            if (push) ent_q[wr_ptr] <= new_ent;
        end
    end

endmodule

// File: doc/lsq_param.md
# lsq_param

Parametrised in-order load/store queue between the decoder/dispatch stage, the two CDB snoop ports and the data cache. Entries are held in one circular queue of configurable depth and snoop both CDBs for their base and store-data operands. The head entry computes its effective address and either reads the dcache (loads) or broadcasts address, data and byte mask to the ROB (stores). Additions over the previous generation: generic widths and depth, misalignment exception reporting, dispatch-cycle CDB bypass, registered CDB output, and a pipeline flush.

## Interface
- DEPTH, 8: queue entries; power of two, >=2.
- DATA_W, 32: data width; fixed at 32 for byte-lane logic.
- ADDR_W, 32: address width.
- TAG_W, 4: ROB tag width. LOCK_W = TAG_W+1. A lock with MSB=1 means "ready". The emitted no-lock value is {1'b1, TAG_W'b0}.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all entries and any in-flight load.
- disp_valid  in  1  dispatch strobe.
- disp_store  in  1  1 = store, 0 = load.
- disp_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- disp_unsigned  in  1  zero-extend the load result.
- disp_tag  in  TAG_W  ROB destination tag.
- disp_offset  in  ADDR_W  sign-extended immediate.
- disp_lock1 / disp_data1  in  LOCK_W / DATA_W  base register operand.
- disp_lock2 / disp_data2  in  LOCK_W / DATA_W  store-data operand.
- full  out  1  count==DEPTH.
- cdb_a_index / cdb_a_data  in  LOCK_W / DATA_W  ALU CDB snoop.
- cdb_b_index / cdb_b_data  in  LOCK_W / DATA_W  LSQ CDB snoop.
- rob_stall  in  1  ROB cannot accept a store broadcast.
- cdb_out_valid  out  1  one-cycle result pulse.
- cdb_out_index  out  LOCK_W  {1'b0, tag}; no-lock value when idle.
- cdb_out_data  out  DATA_W  load result or store data.
- cdb_out_addr  out  ADDR_W  effective address; for loads, the unmasked load address.
- cdb_out_mask  out  4  store byte enables; 0 for loads.
- cdb_out_exc  out  1  misaligned access.
- dcache_read  out  1  read request, held high until done.
- dcache_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dcache_read_done / dcache_read_data  in  1 / DATA_W  read response.

## Operation
- Dispatch: accepted when disp_valid && !full. The entry is written at wr_ptr, wr_ptr increments, count increments. Dispatch while full is dropped with no state change.
- Bypass: on dispatch, if disp_lockN matches a same-cycle CDB index that is not no-lock, the entry stores that CDB data and a no-lock value.
- Wakeup: every valid entry compares lock1 and lock2 against both CDB indices. On a match it captures the data and clears the lock. If both CDBs carry the same index, port A wins.
- Head readiness: base is ready, and for stores the data operand is also ready. Effective address = data1 + offset, modulo 2^ADDR_W.
- Misaligned cases are half with addr[0]=1, word with addr[1:0]!=0, and size 11. The entry retires with exc=1 and data 0, with no dcache access. A store in this case still waits for !rob_stall.
- FSM IDLE:
  - Ready store, !rob_stall: register the CDB output (data shifted to its byte lane, mask = size lanes << addr[1:0]) and pop.
  - Ready, aligned load: go to LOAD, with dcache_read=1 and dcache_addr=addr&~3 from the next cycle.
- FSM LOAD: on dcache_read_done, extract bytes by addr[1:0] and size, then sign- or zero-extend. Register the CDB output, pop, drop dcache_read and return to IDLE.
- Pop: clear the entry, rd_ptr+1, count-1. Dispatch and pop in the same cycle leave count unchanged. Both pointers wrap modulo DEPTH.
- Flush: pointers and count go to 0, all entries become invalid, FSM goes to IDLE and dcache_read goes to 0. A dcache_read_done in the flush cycle is ignored, and dispatch in the flush cycle is dropped. cdb_out_valid is 0 the next cycle.
- Reset: as flush. All outputs are 0 except cdb_out_index, which is no-lock.

## Timing
- Dispatch at edge N: the entry is visible from cycle N+1. An entry that is at the head and ready issues in cycle N+1.
- Store: cdb_out_valid is high for exactly one cycle, in the cycle after the issue decision. Throughput is one store per cycle.
- Load: dcache_read rises the cycle after the issue decision. cdb_out_valid rises the cycle after dcache_read_done. Latency is 2 + dcache latency.
- Misaligned access: one cycle to cdb_out_valid, like a store.
- cdb_out_valid, cdb_out_index, cdb_out_data, cdb_out_addr, cdb_out_mask and cdb_out_exc are all registered. Outside a valid pulse, index is no-lock and the remaining fields are 0.
- full is combinational from count. It goes high the cycle after the DEPTH-th dispatch and low the cycle after a pop.

## Test plan
- Load after reset: LW with base ready 0x100, offset 4; dcache returns 0xDEADBEEF after 3 cycles -> cdb_out_valid=1 with data 0xDEADBEEF, index {0,tag}, and dcache_addr=0x104.
- Byte lanes: LB to addr 0x103 with read data 0x80xxxxxx -> data 0xFFFFFF80. LHU to 0x102 with 0xBEEFxxxx -> 0x0000BEEF.
- Store and stall: SB with data 0x12 to addr 0x201 while rob_stall=1 for 4 cycles -> no output during the stall, then data 0x00001200, mask 0010, addr 0x201.
- Wakeup and bypass: dispatch a load with lock1=3 in the same cycle CDB-A broadcasts index 3 with data 0x40 -> load issues next cycle at 0x40+offset. Repeat with the broadcast two cycles later -> issue waits for it.
- Full and wrap: fill to DEPTH -> full=1, and an extra dispatch is dropped. Drain, then 3*DEPTH back-to-back dispatches -> results in order with no loss.
- Misalign and flush: LW to 0x102 -> exc=1 with no dcache_read. Flush mid-LOAD with dcache_read_done in the same cycle -> no cdb_out_valid, count=0, full=0.
